// File: rtl/seq_detector_param_pkg.sv
// Shared defaults, mode encoding and length clamping for the parametrised
// serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial stream and match-reporting signals of the detector.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
);

  logic               cfg_load;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               moore;
  logic               i_valid;
  logic               i;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  modport master (
    output cfg_load, pat, pat_len, overlap, moore, i_valid, i, cnt_clr,
    input  out, match_cnt, cnt_sat
  );

  modport slave (
    input  cfg_load, pat, pat_len, overlap, moore, i_valid, i, cnt_clr,
    output out, match_cnt, cnt_sat
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that can coincide with an
// increment (clear-and-count-one).
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = (count_q == '1);

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with optional overlap,
// Mealy/Moore output timing and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  mode_e              mode_q, mode_d;
  logic               out_q, out_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN:0]   mask_w;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic               accept;
  logic               hit;

  // Mask is built one bit wider so that len == MAX_LEN yields all ones.
  always_comb begin
    accept  = bus.i_valid & ~bus.cfg_load;
    cand    = {hist_q[MAX_LEN-2:0], bus.i};
    mask_w  = ((MAX_LEN+1)'(1) << len_q) - (MAX_LEN+1)'(1);
    mask    = mask_w[MAX_LEN-1:0];
    fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);
    hit     = accept && (len_q != '0) && (fill_p1 >= {1'b0, len_q})
              && (((cand ^ pat_q) & mask) == '0);
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    mode_d    = mode_q;
    out_d     = hit;
    if (bus.cfg_load) begin
      pat_d     = bus.pat;
      len_d     = LEN_W'(clamp_len(32'(bus.pat_len), MAX_LEN));
      overlap_d = bus.overlap;
      mode_d    = bus.moore ? MODE_MOORE : MODE_MEALY;
      hist_d    = '0;
      fill_d    = '0;
      out_d     = 1'b0;
    end else if (accept) begin
      hist_d = cand;
      // Non-overlap restarts the fill gate; stale history is masked by it.
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q < LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b1;
      mode_q    <= MODE_MEALY;
      out_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    bus.out = (mode_q == MODE_MOORE) ? out_q : hit;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .count (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a monitor pops
// and compares them mid-cycle, before the next rising edge.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;

  logic clk;
  logic rst;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        eo;
    int unsigned ec;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Expected cnt is the registered count visible during the driven cycle.
  task automatic step(input string tag, input logic iv, input logic ib,
                      input logic clr, input logic eo, input int unsigned ec);
    @(negedge clk);
    #1;
    bus.cfg_load = 1'b0;
    bus.i_valid  = iv;
    bus.i        = ib;
    bus.cnt_clr  = clr;
    sb.push_back('{tag, eo, ec});
  endtask

  task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l,
                      input logic ov, input logic mo, input logic ivb,
                      input logic eo, input int unsigned ec);
    @(negedge clk);
    #1;
    bus.cfg_load = 1'b1;
    bus.pat      = p;
    bus.pat_len  = l;
    bus.overlap  = ov;
    bus.moore    = mo;
    bus.i_valid  = ivb;
    bus.i        = ivb;
    bus.cnt_clr  = 1'b0;
    sb.push_back('{tag, eo, ec});
  endtask

  // Feeds n bits oldest-first; o marks the bits expected to complete a match.
  task automatic feed(input string tag, input logic [15:0] v, input int unsigned n,
                      input logic [15:0] o, input int unsigned ec0);
    int unsigned ec;
    ec = ec0;
    for (int unsigned k = 0; k < n; k++) begin
      step($sformatf("%s_b%0d", tag, k + 1), 1'b1, v[n-1-k], 1'b0, o[n-1-k], ec);
      if (o[n-1-k]) ec++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, "/out"}, 32'(bus.out), 32'(e.eo));
        chk({e.tag, "/cnt"}, 32'(bus.match_cnt), e.ec);
        chk({e.tag, "/sat"}, 32'(bus.cnt_sat), 32'(e.ec == 3));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    rst          = 1'b0;
    bus.cfg_load = 1'b0;
    bus.pat      = '0;
    bus.pat_len  = '0;
    bus.overlap  = 1'b0;
    bus.moore    = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i        = 1'b0;
    bus.cnt_clr  = 1'b0;
    #2;
    chk("reset/out", 32'(bus.out), 0);
    chk("reset/cnt", 32'(bus.match_cnt), 0);
    chk("reset/sat", 32'(bus.cnt_sat), 0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Mealy, overlapping
    load("t1_load", 8'b10101, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    feed("t1_mealy_ov", 16'b1010101, 7, 16'b0000101, 0);
    step("t1_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2);
    step("t1_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Mealy, non-overlapping: needs five fresh bits after each hit
    load("t2_load", 8'b10101, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    feed("t2_nonov", 16'b10101010101, 11, 16'b00001000001, 0);
    step("t2_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2);
    step("t2_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Moore with gaps between accepted bits
    load("t3_load", 8'b10101, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("t3_b1", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("t3_gap1", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step("t3_b2", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("t3_b3", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("t3_gap2", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step("t3_b4", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("t3_b5", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("t3_late", 1'b0, 1'b0, 1'b0, 1'b1, 1);
    step("t3_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1);
    step("t3_clr", 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("t3_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Fill gating with an all-zero pattern
    load("t4_load", 8'b000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    feed("t4_fill", 16'b0000, 4, 16'b0011, 0);
    step("t4_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2);
    step("t4_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-stream, then cfg_load mid-stream
    load("t5_load", 8'b10101, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    feed("t5_pre", 16'b101010, 6, 16'b000010, 0);
    @(negedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i       = 1'b1;
    #1;
    chk("t5_hit_before_rst/out", 32'(bus.out), 1);
    rst = 1'b0;
    #1;
    chk("t5_in_rst/out", 32'(bus.out), 0);
    chk("t5_in_rst/cnt", 32'(bus.match_cnt), 0);
    chk("t5_in_rst/sat", 32'(bus.cnt_sat), 0);
    bus.i_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    step("t5_disabled", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    load("t5_reload", 8'b10101, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    feed("t5_post", 16'b10101, 5, 16'b00001, 0);
    step("t5_b6", 1'b1, 1'b0, 1'b0, 1'b0, 1);
    load("t5_cfg_mid", 8'b10101, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    step("t5_after_cfg", 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Saturation, clear during a hit, length clamp, zero length
    step("t6_clr", 1'b0, 1'b0, 1'b1, 1'b0, 1);
    load("t6_load", 8'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("t6_m1", 1'b1, 1'b1, 1'b0, 1'b1, 0);
    step("t6_m2", 1'b1, 1'b1, 1'b0, 1'b1, 1);
    step("t6_m3", 1'b1, 1'b1, 1'b0, 1'b1, 2);
    step("t6_m4", 1'b1, 1'b1, 1'b0, 1'b1, 3);
    step("t6_sat", 1'b0, 1'b0, 1'b0, 1'b0, 3);
    step("t6_clr_hit", 1'b1, 1'b1, 1'b1, 1'b1, 3);
    step("t6_after_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1);
    load("t6_clamp_load", 8'hA5, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    feed("t6_clamp", 16'b10100101, 8, 16'b00000001, 1);
    step("t6_clamp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2);
    load("t6_len0_load", 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    feed("t6_len0", 16'b000, 3, 16'b000, 2);
    step("t6_len0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2);

    for (int unsigned w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #5;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
